conv_job_arbiter: RTL and testbench

- Single-clock scheduler for the 4-tap × 4-sample linear convolution engine.
- Two requesters each submit a convolution job: a 4-coefficient h vector and a 4-sample x vector.
- Grants jobs round-robin, latches operands into execution registers, then streams the 7 results y[0..6] serially, tagged with the requester ID.
- Sits between clock-domain-crossed input collectors (upstream) and the result consumer (downstream).

---
 rtl/conv_pkg.sv | 14 +
 rtl/conv_core.sv | 25 ++
 rtl/conv_job_arbiter.sv | 114 +++++++++++
 tb/tb_conv_job_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and sizing constants for the convolution job arbiter.
package conv_pkg;

    localparam int NTAPS = 4;
    localparam int NOUT  = 7;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/conv_core.sv
// Combinational 4x4 linear convolution: returns y[cnt] = sum of x[i]*h[j] with i+j == cnt.
module conv_core
    import conv_pkg::*;
#(
    parameter int DATA_W = 3,
    parameter int OUT_W  = 8
) (
    input  logic [NTAPS*DATA_W-1:0] h,
    input  logic [NTAPS*DATA_W-1:0] x,
    input  logic [CNT_W-1:0]        cnt,
    output logic [OUT_W-1:0]        y
);

    always_comb begin
        y = '0;
        for (int unsigned i = 0; i < NTAPS; i++) begin
            for (int unsigned j = 0; j < NTAPS; j++) begin
                if (CNT_W'(i + j) == cnt) begin
                    y = y + OUT_W'(h[j*DATA_W +: DATA_W]) * OUT_W'(x[i*DATA_W +: DATA_W]);
                end
            end
        end
    end

endmodule

// File: rtl/conv_job_arbiter.sv
// Round-robin job arbiter for two convolution requesters; latches the winner's
// operands and streams the seven results serially, tagged with the owner id.
module conv_job_arbiter
    import conv_pkg::*;
#(
    parameter int DATA_W = 3,
    parameter int OUT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [NTAPS*DATA_W-1:0] req0_h,
    input  logic [NTAPS*DATA_W-1:0] req0_x,
    input  logic [NTAPS*DATA_W-1:0] req1_h,
    input  logic [NTAPS*DATA_W-1:0] req1_x,
    output logic                    busy,
    output logic                    out_valid,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_id,
    output logic                    out_last
);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    rr_last;
    logic                    owner;
    logic [NTAPS*DATA_W-1:0] exe_h;
    logic [NTAPS*DATA_W-1:0] exe_x;
    logic [OUT_W-1:0]        y;
    logic                    fire;
    logic                    winner;

    // Ready only while idle; on a tie the requester that did not win last time goes.
    always_comb begin
        req_ready = '0;
        if (state == IDLE) begin
            case (req_valid)
                2'b01:   req_ready = 2'b01;
                2'b10:   req_ready = 2'b10;
                2'b11:   req_ready = rr_last ? 2'b01 : 2'b10;
                default: req_ready = '0;
            endcase
        end
    end

    assign fire   = |(req_valid & req_ready);
    assign winner = req_ready[1];
    assign busy   = (state != IDLE);

    // Operand and owner registers carry no reset; they are only read after a transfer.
    always_ff @(posedge clk) begin
        if (fire) begin
            exe_h <= winner ? req1_h : req0_h;
            exe_x <= winner ? req1_x : req0_x;
            owner <= winner;
        end
    end

    conv_core #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) u_core (
        .h   (exe_h),
        .x   (exe_x),
        .cnt (cnt),
        .y   (y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rr_last   <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire) begin
                        state   <= CALC;
                        rr_last <= winner;
                    end
                end
                CALC: begin
                    state <= OUT;
                    cnt   <= '0;
                end
                OUT: begin
                    out_data  <= y;
                    out_valid <= 1'b1;
                    out_id    <= owner;
                    out_last  <= (cnt == CNT_W'(NOUT - 1));
                    if (cnt == CNT_W'(NOUT - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_job_arbiter.sv
// Scoreboard bench for conv_job_arbiter: accepted jobs push their seven expected
// results (value, owner, last flag, edge) and the output monitor pops them.
module tb_conv_job_arbiter;

    localparam int DATA_W = 3;
    localparam int OUT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [1:0]        req_valid = '0;
    logic [1:0]        req_ready;
    logic [11:0]       h0 = '0, x0 = '0, h1 = '0, x1 = '0;
    logic              busy, out_valid, out_id, out_last;
    logic [OUT_W-1:0]  out_data;

    conv_job_arbiter #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_h    (h0),
        .req0_x    (x0),
        .req1_h    (h1),
        .req1_x    (x1),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit id;
        int data;
        bit last;
        int edge_no;
    } exp_t;

    exp_t sb[$];
    int   xfer_id[$];
    int   xfer_edge[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t pe;
    exp_t me;
    logic [11:0] ph, px;

    function automatic int conv_y(logic [11:0] h, logic [11:0] x, int n);
        int s = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (i + j == n) s += int'(h[j*3 +: 3]) * int'(x[i*3 +: 3]);
        return s;
    endfunction

    // Edge counter, handshake legality and job capture into the scoreboard.
    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            total++;
            if (busy && req_ready !== 2'b00) begin
                bad++;
                $display("FAIL ready_busy: req_ready=%b required 00 while busy (edge %0d)", req_ready, cyc);
            end else if (!busy && (req_ready === 2'b11 || (req_ready & ~req_valid) !== 2'b00)) begin
                bad++;
                $display("FAIL ready_legal: req_ready=%b with req_valid=%b (edge %0d)", req_ready, req_valid, cyc);
            end
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    ph = (i == 1) ? h1 : h0;
                    px = (i == 1) ? x1 : x0;
                    xfer_id.push_back(i);
                    xfer_edge.push_back(cyc);
                    for (int n = 0; n < 7; n++) begin
                        pe.id      = (i == 1);
                        pe.data    = conv_y(ph, px, n);
                        pe.last    = (n == 6);
                        pe.edge_no = cyc + 2 + n;
                        sb.push_back(pe);
                    end
                end
            end
        end
    end

    // Output monitor, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out: data=%0d id=%0d at edge %0d, required no strobe", out_data, out_id, cyc);
                end else begin
                    me = sb.pop_front();
                    if (out_data !== 8'(me.data) || out_id !== me.id || out_last !== me.last || cyc != me.edge_no) begin
                        bad++;
                        $display("FAIL result: got data=%0d id=%0d last=%0d edge=%0d, required data=%0d id=%0d last=%0d edge=%0d",
                                 out_data, out_id, out_last, cyc, me.data, me.id, me.last, me.edge_no);
                    end
                end
            end else begin
                if (out_data !== '0 || out_last !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_outputs: data=%0d last=%0d, required 0 0 (edge %0d)", out_data, out_last, cyc);
                end
                if (sb.size() > 0 && sb[0].edge_no <= cyc) begin
                    total++;
                    bad++;
                    $display("FAIL missing_out: no strobe at edge %0d, required data=%0d id=%0d", cyc, sb[0].data, sb[0].id);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic wait_xfers(input int target);
        int n = 0;
        while (xfer_id.size() < target && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (xfer_id.size() < target) begin
            total++;
            bad++;
            $display("FAIL xfer_timeout: transfers=%0d required %0d", xfer_id.size(), target);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() > 0 || busy) && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0 || busy) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d busy=%0d, required 0 0", sb.size(), busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_grant(input string nm, input int idx, input int id, input int prev_edge);
        total++;
        if (idx >= xfer_id.size()) begin
            bad++;
            $display("FAIL %s: transfer %0d absent, required id %0d", nm, idx, id);
        end else if (xfer_id[idx] != id || (prev_edge >= 0 && xfer_edge[idx] != prev_edge + 9)) begin
            bad++;
            $display("FAIL %s: got id=%0d edge=%0d, required id=%0d edge=%0d",
                     nm, xfer_id[idx], xfer_edge[idx], id, prev_edge + 9);
        end
    endtask

    task automatic run_job(input int id, input logic [11:0] h, input logic [11:0] x);
        int base = xfer_id.size();
        @(negedge clk);
        if (id == 1) begin h1 = h; x1 = x; end else begin h0 = h; x0 = x; end
        req_valid = (id == 1) ? 2'b10 : 2'b01;
        wait_xfers(base + 1);
        req_valid = '0;
        check_grant("single_grant", base, id, -1);
        wait_drain();
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_id !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b00) begin
            bad++;
            $display("FAIL reset_state: valid=%0d data=%0d id=%0d last=%0d busy=%0d ready=%b, required all 0",
                     out_valid, out_data, out_id, out_last, busy, req_ready);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_contention();
        int base = xfer_id.size();
        @(negedge clk);
        h0 = {3'd1, 3'd2, 3'd3, 3'd4}; x0 = {3'd2, 3'd0, 3'd5, 3'd1};
        h1 = {3'd7, 3'd0, 3'd1, 3'd6}; x1 = {3'd3, 3'd3, 3'd2, 3'd7};
        req_valid = 2'b11;
        wait_xfers(base + 1);
        req_valid = 2'b10;
        wait_xfers(base + 2);
        req_valid = '0;
        check_grant("contention_first", base, 0, -1);
        if (xfer_edge.size() > base) check_grant("contention_second", base + 1, 1, xfer_edge[base]);
        wait_drain();
    endtask

    task automatic test_fairness();
        int base = xfer_id.size();
        @(negedge clk);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_xfers(base + k + 1);
            if (xfer_id.size() > base + k) begin
                if (xfer_id[base + k] == 1) begin h1 = 12'($urandom); x1 = 12'($urandom); end
                else begin h0 = 12'($urandom); x0 = 12'($urandom); end
            end
        end
        req_valid = '0;
        check_grant("fair_0", base, 0, -1);
        for (int k = 1; k < 4; k++)
            if (xfer_edge.size() > base + k - 1)
                check_grant("fair_n", base + k, k % 2, xfer_edge[base + k - 1]);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int base = xfer_id.size();
        @(negedge clk);
        h1 = {3'd5, 3'd6, 3'd7, 3'd1}; x1 = {3'd2, 3'd4, 3'd6, 3'd3};
        req_valid = 2'b10;
        wait_xfers(base + 1);
        h1 = {3'd1, 3'd7, 3'd2, 3'd6}; x1 = {3'd7, 3'd1, 3'd0, 3'd5};
        wait_xfers(base + 2);
        req_valid = '0;
        check_grant("b2b_first", base, 1, -1);
        if (xfer_edge.size() > base) check_grant("b2b_second", base + 1, 1, xfer_edge[base]);
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int base = xfer_id.size();
        int k;
        int n = 0;
        @(negedge clk);
        h0 = {3'd3, 3'd1, 3'd4, 3'd1}; x0 = {3'd5, 3'd2, 3'd6, 3'd7};
        req_valid = 2'b01;
        wait_xfers(base + 1);
        req_valid = '0;
        k = (xfer_edge.size() > base) ? xfer_edge[base] : cyc;
        while (cyc < k + 4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: valid=%0d data=%0d last=%0d busy=%0d, required all 0",
                     out_valid, out_data, out_last, busy);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = xfer_id.size();
        @(negedge clk);
        h0 = {3'd2, 3'd2, 3'd7, 3'd3}; x0 = {3'd1, 3'd6, 3'd4, 3'd5};
        h1 = {3'd4, 3'd0, 3'd3, 3'd2}; x1 = {3'd7, 3'd7, 3'd1, 3'd0};
        req_valid = 2'b11;
        wait_xfers(base + 1);
        req_valid = 2'b10;
        wait_xfers(base + 2);
        req_valid = '0;
        check_grant("post_reset_tie", base, 0, -1);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_fairness();
        run_job(0, {3'd4, 3'd3, 3'd2, 3'd1}, {3'd1, 3'd1, 3'd1, 3'd1});
        run_job(0, 12'hFFF, 12'hFFF);
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
